// File: rtl/cp0_regfile.sv
// cp0_regfile: system control coprocessor (CP0) for the single-cycle MIPS core.
// Holds Status, Cause, EPC, Count and Compare. It serves mtc0/mfc0 and
// arbitrates interrupt > exception > eret > mtc0 for the retiring instruction.
// It also drives the combinational PC redirect and the writeback flush.
//
// Ports:
//   clk, rst              core clock, async active-high reset
//   cp0_addr, mtc0_en     register number and write strobe
//   w_cpdata / cpdata     write data in / combinational read data out
//   inst_valid, inst_pc   retiring instruction and its PC
//   exc_valid, exc_code   synchronous exception and its ExcCode
//   eret                  return from exception
//   hw_int[5:0]           level-sensitive external interrupt lines
//   int_pending           interrupt would be taken at the next inst_valid
//   flush                 kill writeback of the current instruction
//   redirect_valid/pc     next-PC override for this cycle
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  cp0_addr,
  input  logic        mtc0_en,
  input  logic [31:0] w_cpdata,
  output logic [31:0] cpdata,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        int_pending,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;

  logic [7:0]  im;
  logic        exl, ie;
  logic [1:0]  sw_ip;
  logic [4:0]  exc_code_q;
  logic [5:0]  hw_q;
  logic        timer_flag;
  logic        div_q;
  logic [31:0] epc, count, compare;

  logic [31:0] status, cause, count_inc;
  logic        tick, take_int, take_exc, take_eret, do_mtc0;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign status = {16'b0, im, 6'b0, exl, ie};
  assign cause  = {16'b0, timer_flag | hw_q[5], hw_q[4:0], sw_ip, 1'b0, exc_code_q, 2'b0};

  assign int_pending = ie & ~exl & (|(im & cause[15:8]));

  // Priority decode: each lower event is dropped when a higher one fires.
  assign take_int  = int_pending & inst_valid;
  assign take_exc  = exc_valid & ~take_int;
  assign take_eret = eret & ~take_int & ~exc_valid;
  assign do_mtc0   = mtc0_en & ~take_int & ~exc_valid & ~eret;

  assign wr_count   = do_mtc0 && (cp0_addr == A_COUNT);
  assign wr_compare = do_mtc0 && (cp0_addr == A_COMPARE);
  assign wr_status  = do_mtc0 && (cp0_addr == A_STATUS);
  assign wr_cause   = do_mtc0 && (cp0_addr == A_CAUSE);
  assign wr_epc     = do_mtc0 && (cp0_addr == A_EPC);

  // Divide-by-2 toggles; divide-by-1 ticks every clock.
  assign tick      = (COUNT_DIV == 1) ? 1'b1 : div_q;
  assign count_inc = count + 32'd1;

  // Outputs are forced low while reset is asserted so an in-flight
  // redirect disappears immediately.
  always_comb begin
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'b0;
    if (!rst) begin
      if (take_int || take_exc) begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = EXC_VECTOR;
      end else if (take_eret) begin
        redirect_valid = 1'b1;
        redirect_pc    = epc;
      end
    end
  end

  always_comb begin
    cpdata = 32'b0;
    case (cp0_addr)
      A_COUNT:   cpdata = count;
      A_COMPARE: cpdata = compare;
      A_STATUS:  cpdata = status;
      A_CAUSE:   cpdata = cause;
      A_EPC:     cpdata = epc;
      default:   cpdata = 32'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      sw_ip      <= '0;
      exc_code_q <= '0;
      hw_q       <= '0;
      timer_flag <= 1'b0;
      div_q      <= 1'b0;
      epc        <= '0;
      count      <= '0;
      compare    <= '0;
    end else begin
      hw_q  <= hw_int;
      div_q <= (COUNT_DIV == 1) ? 1'b0 : ~div_q;

      if (wr_count)  count <= w_cpdata;
      else if (tick) count <= count_inc;

      if (wr_compare) compare <= w_cpdata;

      // Clear by Compare write beats a same-edge match.
      if (wr_compare)
        timer_flag <= 1'b0;
      else if (tick && !wr_count && count_inc == compare)
        timer_flag <= 1'b1;

      if (take_int) begin
        epc        <= inst_pc;
        exc_code_q <= 5'd0;
        exl        <= 1'b1;
      end else if (take_exc) begin
        exc_code_q <= exc_code;
        // Nested exception keeps the original return address.
        if (!exl) epc <= inst_pc;
        exl <= 1'b1;
      end else if (take_eret) begin
        exl <= 1'b0;
      end else begin
        if (wr_status) begin
          im  <= w_cpdata[15:8];
          exl <= w_cpdata[1];
          ie  <= w_cpdata[0];
        end
        if (wr_cause) sw_ip <= w_cpdata[9:8];
        if (wr_epc)   epc   <= w_cpdata;
      end
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile (COUNT_DIV=1). The stimulus pushes expected
// output values for the current cycle. The monitor pops and compares them on
// the falling edge.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cp0_addr;
  logic        mtc0_en;
  logic [31:0] w_cpdata;
  logic [31:0] cpdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic [5:0]  hw_int;
  logic        int_pending, flush, redirect_valid;
  logic [31:0] redirect_pc;

  cp0_regfile #(.EXC_VECTOR(32'h0000_0380), .COUNT_DIV(1)) dut (
    .clk(clk), .rst(rst), .cp0_addr(cp0_addr), .mtc0_en(mtc0_en),
    .w_cpdata(w_cpdata), .cpdata(cpdata), .inst_valid(inst_valid),
    .inst_pc(inst_pc), .exc_valid(exc_valid), .exc_code(exc_code),
    .eret(eret), .hw_int(hw_int), .int_pending(int_pending), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;   // 0 cpdata, 1 redirect_valid, 2 redirect_pc, 3 flush, 4 int_pending
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return cpdata;
      1: return {31'b0, redirect_valid};
      2: return redirect_pc;
      3: return {31'b0, flush};
      default: return {31'b0, int_pending};
    endcase
  endfunction

  // Monitor: everything queued during this cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sbq.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic chk(string n, int sel, logic [31:0] v);
    sbq.push_back('{n, sel, v});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    mtc0_en = 0; exc_valid = 0; eret = 0; inst_valid = 0;
    w_cpdata = 0; exc_code = 0; inst_pc = 0;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    mtc0_en = 1; cp0_addr = a; w_cpdata = d;
  endtask

  task automatic rd(logic [4:0] a, logic [31:0] v);
    cp0_addr = a;
    chk($sformatf("read_%0d", a), 0, v);
  endtask

  task automatic chk_redir(string n, logic rv, logic [31:0] pc, logic fl);
    chk({n, "_rv"}, 1, {31'b0, rv});
    chk({n, "_pc"}, 2, pc);
    chk({n, "_flush"}, 3, {31'b0, fl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] rst_addrs [6];
    rst_addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    rst = 1; cp0_addr = 0; mtc0_en = 0; w_cpdata = 0; inst_valid = 0;
    inst_pc = 0; exc_valid = 0; exc_code = 0; eret = 0; hw_int = 0;

    // Reset state: every register reads 0 while reset is held.
    foreach (rst_addrs[i]) begin
      nxt();
      rd(rst_addrs[i], 32'h0);
    end
    chk_redir("reset", 0, 32'h0, 0);
    chk("reset_intp", 4, 0);
    nxt(); rst = 0;

    // Status write mask; unimplemented address ignores writes.
    nxt(); wr(12, 32'hFFFF_FF03);
    nxt(); rd(12, 32'h0000_FF03); chk("exl_masks_int", 4, 0);
    nxt(); wr(3, 32'hFFFF_FFFF);
    nxt(); rd(3, 32'h0);
    nxt(); wr(12, 32'h0);
    nxt(); rd(12, 32'h0);

    // Exception from EXL=0, then nested exception.
    nxt(); exc_valid = 1; exc_code = 8; inst_pc = 32'h100;
    chk_redir("exc1", 1, 32'h380, 1);
    nxt(); rd(14, 32'h100);
    nxt(); rd(13, 32'h20);
    nxt(); rd(12, 32'h2);
    nxt(); exc_valid = 1; exc_code = 12; inst_pc = 32'h200;
    chk_redir("exc2", 1, 32'h380, 1);
    nxt(); rd(14, 32'h100);
    nxt(); rd(13, 32'h30);

    // eret returns to the registered EPC without flushing.
    nxt(); wr(14, 32'h104);
    nxt(); eret = 1; chk_redir("eret", 1, 32'h104, 0);
    nxt(); rd(12, 32'h0);

    // Timer interrupt.
    nxt(); wr(11, 32'h5);
    nxt(); wr(9, 32'h0);
    nxt(); wr(12, 32'h8001);
    nxt(); rd(9, 32'd1); chk("tmr_intp0", 4, 0);
    nxt(); rd(9, 32'd2);
    nxt(); rd(9, 32'd3);
    nxt(); rd(9, 32'd4); chk("tmr_intp1", 4, 0);
    nxt(); rd(9, 32'd5); chk("tmr_intp2", 4, 1);
    nxt(); rd(13, 32'h8030); inst_valid = 1; inst_pc = 32'h40;
    chk_redir("int", 1, 32'h380, 1);
    nxt(); rd(14, 32'h40);
    nxt(); rd(13, 32'h8000); chk("int_exl_mask", 4, 0);
    nxt(); wr(11, 32'h7FFF_FFFF);
    nxt(); rd(13, 32'h0);

    // Exception drops a same-cycle mtc0.
    nxt(); wr(12, 32'h0);
    nxt(); wr(14, 32'hDEAD_0000); exc_valid = 1; exc_code = 10; inst_pc = 32'h300;
    chk_redir("exc_mtc0", 1, 32'h380, 1);
    nxt(); rd(14, 32'h300);
    nxt(); rd(13, 32'h28);

    // Interrupt beats exception (software IP0).
    nxt(); wr(13, 32'h100);
    nxt(); wr(12, 32'h101);
    nxt(); chk("sw_intp", 4, 1);
    inst_valid = 1; exc_valid = 1; exc_code = 9; inst_pc = 32'h500;
    chk_redir("int_exc", 1, 32'h380, 1);
    nxt(); rd(13, 32'h100); chk("sw_int_exl", 4, 0);
    nxt(); rd(14, 32'h500);

    // Count wrap.
    nxt(); wr(9, 32'hFFFF_FFFF);
    nxt(); rd(9, 32'hFFFF_FFFF);
    nxt(); rd(9, 32'h0);

    // Hardware line sampled into Cause[12].
    nxt(); hw_int = 6'b000100;
    nxt(); rd(13, 32'h1100);
    nxt(); hw_int = 0;

    // Reset in the middle of an exception.
    nxt(); exc_valid = 1; exc_code = 8; inst_pc = 32'h600; cp0_addr = 14;
    #1 rst = 1;
    chk_redir("rst_mid", 0, 32'h0, 0);
    chk("rst_epc", 0, 32'h0);

    nxt();
    @(negedge clk);
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- System control coprocessor (CP0) for the single-cycle MIPS core.
- Responder side of the ALU's mtc0/mfc0 interface:
  - accepts write data on w_cpdata;
  - returns register contents on cpdata.
- Owns exception/interrupt state: Status, Cause, EPC, Count, Compare.
- Produces the PC redirect for exceptions, interrupts and eret; the fetch PC mux consumes it in the same cycle.

Parameters:
- EXC_VECTOR, 32'h0000_0380, PC loaded on any exception or interrupt.
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (legal values 1 or 2).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cp0_addr  in  5  register number (instruction rd field) for mtc0/mfc0.
- mtc0_en  in  1  write strobe for the current instruction.
- w_cpdata  in  32  write data from the ALU.
- cpdata  out  32  combinational read of register cp0_addr.
- inst_valid  in  1  an instruction retires this cycle (interrupt sampling point).
- inst_pc  in  32  PC of the current instruction.
- exc_valid  in  1  synchronous exception raised by the current instruction.
- exc_code  in  5  ExcCode: 8 syscall, 9 break, 12 overflow, 10 reserved instruction.
- eret  in  1  current instruction is eret.
- hw_int  in  6  external interrupt lines, level-sensitive, already synchronised.
- int_pending  out  1  interrupt will be taken at next inst_valid.
- flush  out  1  suppress register/memory writeback of the current instruction.
- redirect_valid  out  1  override next PC this cycle.
- redirect_pc  out  32  target when redirect_valid=1.

Behaviour:
- Registers: Count=9, Compare=11, Status=12, Cause=13, EPC=14. All other addresses read 0; writes to them are ignored.
- Status bits:
  - writable: [15:8] IM, [1] EXL, [0] IE;
  - all other bits read 0.
- Cause bits:
  - [31] BD: always 0.
  - [15] IP7 = timer_flag | hw_int[5].
  - [14:10] = hw_int[4:0], sampled every clock.
  - [9:8]: software IP, writable.
  - [6:2]: ExcCode.
  - other bits: 0.
- EPC and Compare are fully writable. Count is writable.
- Reset (async): Status, Cause, EPC, Count, Compare, timer_flag and divider all 0. Outputs int_pending, flush and redirect_valid are 0; redirect_pc = 0.
- Read: cpdata is combinational from registered state. A write is visible to a read the cycle after mtc0. There is no same-cycle bypass.
- Count:
  - increments by 1 on each divider tick; wraps 0xFFFFFFFF -> 0;
  - an mtc0 to Count loads w_cpdata and suppresses that cycle's increment.
- Timer:
  - when the incremented Count equals Compare, timer_flag sets on that edge;
  - an mtc0 to Compare clears timer_flag; clear wins over a same-cycle set.
- int_pending = Status.IE & ~Status.EXL & |(Status[15:8] & Cause[15:8]). It is combinational.
- Event priority within a cycle (highest first): interrupt, exc_valid, eret, mtc0. A lower-priority event is dropped entirely, including any mtc0 of the same instruction.
- Interrupt (int_pending & inst_valid):
  - EPC <= inst_pc; ExcCode <= 0; EXL <= 1;
  - flush=1; redirect_valid=1; redirect_pc=EXC_VECTOR.
- Exception (exc_valid, no interrupt):
  - ExcCode <= exc_code; flush=1; redirect to EXC_VECTOR.
  - If EXL=0: EPC <= inst_pc and EXL <= 1.
  - If EXL=1 already: EPC unchanged.
- eret:
  - EXL <= 0; redirect_valid=1; redirect_pc = current registered EPC.
  - flush=0 (eret writes nothing).
- Redirect and flush outputs are combinational in the same cycle. They take effect at the next clock edge through the PC register.
- Reset mid-exception: state clears immediately; redirect deasserts asynchronously.

Test Plan:
1. Reset -> read addresses 9/11/12/13/14 all return 0. Read address 3 returns 0. redirect_valid=0.
2. mtc0 Status=32'hFFFF_FF03 -> next-cycle read returns 32'h0000_FF03. mtc0 to address 3 followed by a read of address 3 -> 0.
3. exc_valid, exc_code=8, inst_pc=32'h0000_0100, EXL=0 -> same cycle: redirect_pc=32'h0000_0380, flush=1. Next cycle: EPC=32'h100, Cause=32'h0000_0020, Status.EXL=1. A second exception with code 12 at pc 32'h200 -> EPC stays 32'h100, Cause=32'h0000_0030.
4. eret with EPC=32'h0000_0104 -> redirect_pc=32'h104, flush=0. EXL clears next cycle.
5. COUNT_DIV=1: Compare=5, Count=0, Status=32'h0000_8001 -> Count reaches 5 after 5 clocks, and Cause bit15 sets on that edge. int_pending=1. Next inst_valid with inst_pc=32'h40 -> redirect to 32'h380, EPC=32'h40, ExcCode=0. mtc0 Compare then clears bit15.
6. Simultaneous cases:
   - mtc0 EPC=32'hDEAD_0000 with exc_valid at pc 32'h300 -> EPC=32'h300 (mtc0 dropped).
   - int_pending with exc_valid -> ExcCode=0.
   - mtc0 Count=32'hFFFF_FFFF, then one tick -> Count=0.
